// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment table and anode patterns for the display scanner
package seg7_pkg;
   typedef enum logic {DEAD, ON} state_t;
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   localparam logic [3:0] ANODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: nibble plus blank/dp to active-low segment byte
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg
);
   assign seg = {~dp, blank ? 7'h7F : seg_encode(nibble)};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed seven-segment scanner with frame-boundary value commit
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int CLK_DIV  = 100000,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic        value_valid,
   input  logic [3:0]  dp_in,
   output logic        busy,
   output logic        frame_tick,
   output logic [3:0]  an,
   output logic [7:0]  out
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   logic [1:0] digit, digit_d;
   state_t state, state_d;
   logic live, tick, commit, blank;
   logic [15:0] shadow, shadow_d, pending;
   logic [3:0] nib, an_d;
   logic [7:0] seg, out_d;
   assign tick = cnt == CW'(CLK_DIV - 1);
   assign commit = tick && digit == 2'd3;
   assign frame_tick = commit;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         shadow <= '0;
         pending <= '0;
         busy <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         shadow <= shadow_d;
         if (value_valid) pending <= value_in;
         busy <= !commit && (busy || value_valid);
      end
   // live holds the display dark until the first slot boundary after reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= DEAD;
         digit <= 2'd3;
         live <= 1'b0;
         an <= 4'hF;
         out <= 8'hFF;
      end else begin
         state <= state_d;
         digit <= digit_d;
         live <= live | tick;
         an <= an_d;
         out <= out_d;
      end
   always_comb begin
      digit_d = tick ? digit + 2'd1 : digit;
      state_d = (tick || !live) ? DEAD : ON;
   end
   // outputs are registered, so they are built from next-cycle digit and shadow
   always_comb begin
      shadow_d = !commit ? shadow : value_valid ? value_in : busy ? pending : shadow;
      nib = shadow_d[{digit_d, 2'b00} +: 4];
      blank = BLANK_LZ && digit_d != 2'd0 && (shadow_d >> {digit_d, 2'b00}) == 16'h0;
      an_d = state_d == ON ? ANODE[digit_d] : 4'hF;
      out_d = state_d == ON ? seg : 8'hFF;
   end
   seg7_encode u_enc (
      .nibble(nib),
      .blank (blank),
      .dp    (dp_in[digit_d]),
      .seg   (seg)
   );
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl with and without leading-zero blanking
module tb_seg7_scan_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic [15:0] value_in;
   logic value_valid;
   logic [3:0] dp_in;
   logic busy0, busy1, ft0, ft1;
   logic [3:0] an0, an1;
   logic [7:0] out0, out1;
   int n_vec = 0;
   int n_err = 0;
   typedef struct {
      logic [3:0] an;
      logic [7:0] o0, o1;
      bit cb, b, cf, f;
   } exp_t;
   typedef struct {
      logic [15:0] v;
      logic [3:0] dp;
      int st;
      bit junk;
      logic [31:0] o0, o1;
   } vec_t;
   exp_t q[$];
   exp_t e;
   vec_t tv[6];
   logic [31:0] cur_o0, cur_o1;
   logic [3:0] cur_dp;
   always #5 clk = ~clk;
   seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid), .dp_in(dp_in),
      .busy(busy0), .frame_tick(ft0), .an(an0), .out(out0)
   );
   seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid), .dp_in(dp_in),
      .busy(busy1), .frame_tick(ft1), .an(an1), .out(out1)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic push(input logic [3:0] an, input logic [7:0] o0, input logic [7:0] o1,
                       input bit cb, input bit b, input bit cf, input bit f);
      exp_t x;
      x.an = an; x.o0 = o0; x.o1 = o1; x.cb = cb; x.b = b; x.cf = cf; x.f = f;
      q.push_back(x);
   endtask
   task automatic push_startup(input bit b2, input bit b3);
      for (int c = 0; c < 4; c++)
         push(4'hF, 8'hFF, 8'hFF, c != 1, c == 2 ? b2 : (c == 3 ? b3 : 1'b0), c == 0 || c == 3, c == 3);
   endtask
   task automatic push_frame(input logic [31:0] o0, input logic [31:0] o1, input int len, input bit bl);
      for (int j = 0; j < len; j++) begin
         int d;
         bit on;
         d = j / 4;
         on = (j % 4) != 0;
         push(on ? ~(4'b0001 << d) : 4'hF, on ? o0[8*d +: 8] : 8'hFF, on ? o1[8*d +: 8] : 8'hFF,
              j == 0 || j == len - 1, j == 0 ? 1'b0 : bl, j == len - 1, j == 15);
      end
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      value_valid = 1'b0;
      dp_in = 4'h0;
      #1;
      chk("rst_an0", an0, 4'hF);
      chk("rst_an1", an1, 4'hF);
      chk("rst_out0", out0, 8'hFF);
      chk("rst_out1", out1, 8'hFF);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_ft0", ft0, 1'b0);
      repeat (3) @(posedge clk);
      chk("rst_hold_an0", an0, 4'hF);
      #1 rst_n = 1'b1;
   endtask
   task automatic cyc(input bit vv, input logic [15:0] v);
      @(negedge clk);
      value_valid = vv;
      value_in = v;
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("an0", an0, e.an);
         chk("an1", an1, e.an);
         chk("out0", out0, e.o0);
         chk("out1", out1, e.o1);
         if (e.cb) begin
            chk("busy0", busy0, e.b);
            chk("busy1", busy1, e.b);
         end
         if (e.cf) begin
            chk("frame_tick0", ft0, e.f);
            chk("frame_tick1", ft1, e.f);
         end
      end
   initial begin
      tv[0] = '{16'h00F0, 4'h0, 5, 1'b1, 32'hC0C08EC0, 32'hFFFF8EC0};
      tv[1] = '{16'h0000, 4'h0, 5, 1'b0, 32'hC0C0C0C0, 32'hFFFFFFC0};
      tv[2] = '{16'h1234, 4'h4, 5, 1'b0, 32'hF924B099, 32'hF924B099};
      tv[3] = '{16'hBEEF, 4'h0, 15, 1'b0, 32'h8386868E, 32'h8386868E};
      tv[4] = '{16'h000A, 4'h8, 5, 1'b0, 32'h40C0C088, 32'h7FFFFF88};
      tv[5] = '{16'h0507, 4'h0, 5, 1'b0, 32'hC092C0F8, 32'hFF92C0F8};
      rst_n = 1'b1;
      value_valid = 1'b0;
      value_in = 16'h0;
      dp_in = 4'h0;
      do_reset();
      push_startup(1'b0, 1'b0);
      push_frame(32'hC0C0C0C0, 32'hFFFFFFC0, 16, 1'b0);
      repeat (20) cyc(1'b0, 16'h0);
      do_reset();
      push_startup(1'b1, 1'b1);
      cyc(1'b0, 16'h0);
      cyc(1'b1, 16'h1234);
      cyc(1'b0, 16'h0);
      cyc(1'b0, 16'h0);
      cur_o0 = 32'hF9A4B099;
      cur_o1 = 32'hF9A4B099;
      cur_dp = 4'h0;
      for (int i = 0; i < 6; i++) begin
         push_frame(cur_o0, cur_o1, 16, tv[i].st != 15);
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 0) dp_in = cur_dp;
            value_valid = (j == tv[i].st) || (tv[i].junk && j == 1);
            value_in = (tv[i].junk && j == 1) ? 16'hABCD : tv[i].v;
         end
         cur_o0 = tv[i].o0;
         cur_o1 = tv[i].o1;
         cur_dp = tv[i].dp;
      end
      push_frame(cur_o0, cur_o1, 14, 1'b1);
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (j == 0) dp_in = cur_dp;
         value_valid = j == 5;
         value_in = 16'h5555;
      end
      do_reset();
      push_startup(1'b0, 1'b0);
      push_frame(32'hC0C0C0C0, 32'hFFFFFFC0, 16, 1'b0);
      repeat (20) cyc(1'b0, 16'h0);
      for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
      chk("drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed 4-digit seven-segment display controller for the processor's 16-bit result bus. It owns a refresh prescaler and a digit-scan state machine, and inserts anode dead time between digits. It latches new values tear-free at frame boundaries and encodes hex nibbles to segments. It sits between the processor's result output and the board's an/out pins in the top-level machine.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot (>=4); 100 MHz gives a 1 kHz digit rate.
BLANK_LZ, 0, 1 = blank leading-zero digits 3..1; digit 0 is never blanked.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value_in  input  16  hex value to display; digit k = value_in[4k+3:4k]
value_valid  input  1  1-cycle load strobe for value_in
dp_in  input  4  decimal point enable per digit, 1 = lit; sampled live, not shadowed
busy  output  1  pending value not yet committed to the display
frame_tick  output  1  1-cycle pulse on each commit slot (digit 3->0 boundary)
an  output  4  anodes, active-low, one-cold; an[k] = digit k
out  output  8  segments, active-low; out[7] = dp, out[6:0] = g,f,e,d,c,b,a

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately: an=4'b1111, out=8'hFF, busy=0, frame_tick=0. Also: prescaler=0, digit=3, state=DEAD, shadow=16'h0000, pending discarded.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick = (count==CLK_DIV-1).
- States:
  - DEAD: an=1111, out=FF; lasts exactly 1 cycle, then -> ON.
  - ON: an = one-cold(digit), out = {~dp_in[digit], seg(nibble)}.
- On tick: digit <= digit+1 mod 4, and state -> DEAD for the following cycle.
- Timing after reset release: first tick at cycle CLK_DIV-1, DEAD at cycle CLK_DIV, digit 0 ON from cycle CLK_DIV+1.
- an and out are registered. Each digit is ON for CLK_DIV-1 cycles per slot.
- Load:
  - value_valid=1 captures value_in into pending and sets busy; the last strobe before commit wins.
  - Commit happens on a tick where digit==3: shadow <= pending, busy <= 0, frame_tick=1 on that tick cycle.
  - value_valid on the commit tick cycle: value_in goes straight to shadow and busy stays 0.
  - No commit when nothing is pending; shadow holds.
- The displayed nibble always comes from shadow, never from pending or value_in, so there is no tearing within a frame.
- Leading-zero blanking (BLANK_LZ=1): digit k in 3..1 is blanked when shadow nibbles k..3 are all zero. A blanked digit has out[6:0]=7'h7F; an is still driven and the dp still follows dp_in.
- Encoding (active-low, dp off), 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Reset mid-operation: all state is lost and scanning restarts per the first-tick timing above.

Decomposition:
- Package seg7_pkg:
  - state enum {DEAD, ON}
  - 16-entry SEG_HEX constant table (active-low, 7 bits)
  - ANODE one-cold constant array
  - function seg_encode(nibble)
- Sub-module seg7_encode: combinational nibble + blank + dp -> 8-bit out. It is instantiated once, fed by a digit mux.
- Prescaler, scan FSM and shadow/pending registers remain in seg7_scan_ctrl.

Test Plan:
1. Reset, CLK_DIV=4, no load: an=1111, out=FF through cycle 4. From cycle 5, digit 0 shows an=1110, out=C0 for 3 cycles, then 1 DEAD cycle, then an=1101, out=C0.
2. value_valid with 16'h1234 at cycle 1: busy=1 until the first tick (cycle 3), then frame_tick=1 and busy=0. The frame then shows 1110/99, 1101/B0, 1011/A4, 0111/F9, with an=1111, out=FF for one cycle between each.
3. Tear test: mid-frame strobes of 16'hABCD then 16'h00F0. The current frame is unchanged and busy stays high; the next frame displays only 00F0 (digit0 C0, digit1 8E, digits 2,3 C0).
4. BLANK_LZ=1 with 16'h00F0: digits 3,2 out=FF, digit1 8E, digit0 C0. With 16'h0000: only digit0 shows C0, all others FF.
5. dp_in=4'b0100 with 16'h1234: digit2 out=24 and the other digits are unchanged. A strobe on the exact commit tick is visible in the same frame with busy never set.
6. rst_n low mid-ON of digit 2: an=1111, out=FF immediately (asynchronously), busy=0 and the pending value is lost. After release, case 1 timing repeats with shadow=0.
